apf_keypad: RTL and testbench
=============================

# apf_keypad

Keyboard-to-handset responder for the APF MP1000 core. It turns the MiSTer `ps2_key` event stream into the key state of both APF hand controllers. Each handset has a 12-key keypad, a 4-way joystick and a fire button. The block answers the CPU-side row scan, which arrives from the PIA, with active-low column data. It sits between the HPS keyboard input and the PIA port inputs in `MP1000`.

## Interface
Parameters:
- `P2_EN`, default 1: enables the player-2 handset.
  - When 0, all player-2 outputs are held at 1.
  - Player-2 scancodes are ignored.

Ports:
- `clk_sys`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `ps2_key`  in  11  MiSTer key event, three fields:
  - `[10]` toggles once per event.
  - `[9]` is 1 for press, 0 for release.
  - `[8]` is the E0-extended flag.
  - `[7:0]` is the Set-2 scancode.
- `row_sel_n`  in  4  row scan from the PIA; active-low; several rows may be low at once.
- `p1_col_n`  out  4  player-1 column response, active-low.
- `p2_col_n`  out  4  player-2 column response, active-low.
- `p1_fire_n`  out  1  player-1 fire, active-low.
- `p2_fire_n`  out  1  player-2 fire, active-low.

## Operation
- Key state: 34 registers, 1 = pressed; 16 matrix keys plus fire, per player.
- Matrix layout per player, columns 0..3 in each row:
  - row0: 1, 2, 3, Up
  - row1: 4, 5, 6, Down
  - row2: 7, 8, 9, Left
  - row3: Cl, 0, En, Right
- Player-1 scancodes (ext = `ps2_key[8]`):
  - Digits 1..9 and 0 on the main row: 16, 1E, 26, 25, 2E, 36, 3D, 3E, 46, 45.
  - Cl = 66 (Backspace); En = 5A with ext=0.
  - Up = E0 75, Down = E0 72, Left = E0 6B, Right = E0 74.
  - Fire = 29 (Space).
- Player-2 scancodes:
  - Numpad digits 1..9 and 0: 69, 72, 7A, 6B, 73, 74, 6C, 75, 7D, 70, all with ext=0.
  - Cl = 71 (numpad '.'); En = E0 5A.
  - Up = 1D (W), Down = 1B (S), Left = 1C (A), Right = 23 (D).
  - Fire = 14 with ext=0 (Left Ctrl).
- Decoding compares the full 9-bit code {ext, scancode}. Example: 075 is P2 digit 8, while 175 is P1 Up.
- Event detection:
  - A register `tgl_q` holds the last sampled `ps2_key[10]`.
  - An event occurs on any clock where `ps2_key[10] != tgl_q`.
  - On an event, the decoded key bit is set to `ps2_key[9]`; `tgl_q` is updated every clock.
- Unmapped codes: the event is consumed and no state changes.
- Repeated press (typematic) of a held key: no change.
- Release of a key that is not held: no change.
- Column response:
  - `pX_col_n[c]` = NOT (OR over rows r with `row_sel_n[r]`=0 of `state[r][c]`).
  - All rows deselected (`row_sel_n`=F) gives F.
- Fire: `pX_fire_n` = NOT `fire_state`; independent of `row_sel_n`.
- Reset:
  - Clears all key state.
  - Loads `tgl_q` from `ps2_key[10]`, so a pending toggle level does not produce a spurious event after reset.
  - Drives `p1_col_n`, `p2_col_n` = F and both fire outputs = 1.
  - A press arriving on a reset clock is dropped.

## Timing
- All outputs are registered.
- Row-scan latency:
  - `row_sel_n` is sampled at edge M; columns reflect it after edge M (1 clock).
  - The CPU read path must tolerate 1 `clk_sys` of latency; at CPU clock rates this is negligible.
- Key-event latency:
  - The event is sampled at edge N and updates state at edge N.
  - Column and fire outputs reflect it after edge N+1 (2 clocks from the input change).
- Simultaneous events:
  - If a row change and a key event occur on the same edge, the output after that edge uses the old state and the new row.
  - The updated state appears one clock later.
- Event rate: at most one event per clock. Back-to-back toggles on consecutive clocks are each processed.

## Test plan
- Reset, with `ps2_key[10]`=1 held through reset -> no state change after reset; outputs: cols F, fire 1.
- Press "5" (toggle, 200 = press, code 2E), then `row_sel_n`=D -> `p1_col_n`=D. Then `row_sel_n`=E -> F. Then `row_sel_n`=C -> D.
- Press E0 75 (P1 Up) and 075 (P2 8), `row_sel_n`=E -> `p1_col_n`=7. With `row_sel_n`=B -> `p2_col_n`=D. Release both -> F on each.
- Press Space and Left Ctrl -> `p1_fire_n`=0 and `p2_fire_n`=0 two clocks later, for any `row_sel_n`. Release -> 1.
- Key event and row change on the same edge -> output after that edge shows old key state; next clock shows new. Unmapped code 0x1A -> no output change.
- `P2_EN`=0: press numpad keys and Left Ctrl -> `p2_col_n`=F and `p2_fire_n`=1 throughout; P1 unaffected.

Source files
------------

// File: rtl/apf_keypad.sv
// APF MP1000 hand-controller responder: decodes MiSTer ps2_key events into
// two handsets of keypad/joystick/fire state and answers the PIA row scan.
module apf_keypad #(
  parameter bit P2_EN = 1'b1
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [10:0] ps2_key,
  input  logic [3:0]  row_sel_n,
  output logic [3:0]  p1_col_n,
  output logic [3:0]  p2_col_n,
  output logic        p1_fire_n,
  output logic        p2_fire_n
);

  typedef enum logic [1:0] {TGT_NONE, TGT_P1, TGT_P2} tgt_e;

  typedef struct packed {
    tgt_e       tgt;
    logic       fire;
    logic [3:0] idx;   // row*4 + column in the handset matrix
  } dec_t;

  function automatic dec_t mk_key(tgt_e t, logic [3:0] i);
    return '{tgt: t, fire: 1'b0, idx: i};
  endfunction

  function automatic dec_t mk_fire(tgt_e t);
    return '{tgt: t, fire: 1'b1, idx: 4'd0};
  endfunction

  function automatic logic [3:0] scan(logic [15:0] keys, logic [3:0] rows_n);
    logic [3:0] hit;
    hit = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        hit[c] = hit[c] | (keys[r*4+c] & ~rows_n[r]);
    return ~hit;
  endfunction

  logic        tgl_q;
  logic [15:0] p1_keys, p2_keys;
  logic        p1_fire, p2_fire;
  logic        key_event;
  dec_t        dec;

  assign key_event = ps2_key[10] != tgl_q;

  // Full 9-bit {ext, scancode} compare: P1 arrows and P2 numpad share low bytes.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    dec = '{tgt: TGT_NONE, fire: 1'b0, idx: 4'd0};
    case ({ps2_key[8], ps2_key[7:0]})
      9'h016: dec = mk_key(TGT_P1, 4'd0);
      9'h01E: dec = mk_key(TGT_P1, 4'd1);
      9'h026: dec = mk_key(TGT_P1, 4'd2);
      9'h175: dec = mk_key(TGT_P1, 4'd3);
      9'h025: dec = mk_key(TGT_P1, 4'd4);
      9'h02E: dec = mk_key(TGT_P1, 4'd5);
      9'h036: dec = mk_key(TGT_P1, 4'd6);
      9'h172: dec = mk_key(TGT_P1, 4'd7);
      9'h03D: dec = mk_key(TGT_P1, 4'd8);
      9'h03E: dec = mk_key(TGT_P1, 4'd9);
      9'h046: dec = mk_key(TGT_P1, 4'd10);
      9'h16B: dec = mk_key(TGT_P1, 4'd11);
      9'h066: dec = mk_key(TGT_P1, 4'd12);
      9'h045: dec = mk_key(TGT_P1, 4'd13);
      9'h05A: dec = mk_key(TGT_P1, 4'd14);
      9'h174: dec = mk_key(TGT_P1, 4'd15);
      9'h029: dec = mk_fire(TGT_P1);
      9'h069: dec = mk_key(TGT_P2, 4'd0);
      9'h072: dec = mk_key(TGT_P2, 4'd1);
      9'h07A: dec = mk_key(TGT_P2, 4'd2);
      9'h01D: dec = mk_key(TGT_P2, 4'd3);
      9'h06B: dec = mk_key(TGT_P2, 4'd4);
      9'h073: dec = mk_key(TGT_P2, 4'd5);
      9'h074: dec = mk_key(TGT_P2, 4'd6);
      9'h01B: dec = mk_key(TGT_P2, 4'd7);
      9'h06C: dec = mk_key(TGT_P2, 4'd8);
      9'h075: dec = mk_key(TGT_P2, 4'd9);
      9'h07D: dec = mk_key(TGT_P2, 4'd10);
      9'h01C: dec = mk_key(TGT_P2, 4'd11);
      9'h071: dec = mk_key(TGT_P2, 4'd12);
      9'h070: dec = mk_key(TGT_P2, 4'd13);
      9'h15A: dec = mk_key(TGT_P2, 4'd14);
      9'h023: dec = mk_key(TGT_P2, 4'd15);
      9'h014: dec = mk_fire(TGT_P2);
      default: ;
    endcase
    if (!P2_EN && dec.tgt == TGT_P2) dec.tgt = TGT_NONE;
  end

  always_ff @(posedge clk_sys) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    // Tracking the toggle level through reset keeps a pending edge from firing later.
    tgl_q <= ps2_key[10];
    if (reset) begin
      p1_keys   <= '0;
      p2_keys   <= '0;
      p1_fire   <= 1'b0;
      p2_fire   <= 1'b0;
      p1_col_n  <= 4'hF;
      p2_col_n  <= 4'hF;
      p1_fire_n <= 1'b1;
      p2_fire_n <= 1'b1;
    end else begin
      if (key_event) begin
        case (dec.tgt)
          TGT_P1: if (dec.fire) p1_fire <= ps2_key[9]; else p1_keys[dec.idx] <= ps2_key[9];
          TGT_P2: if (dec.fire) p2_fire <= ps2_key[9]; else p2_keys[dec.idx] <= ps2_key[9];
          default: ;
        endcase
      end
      // Outputs use pre-edge key state with the freshly sampled row scan.
      p1_col_n  <= scan(p1_keys, row_sel_n);
      p1_fire_n <= ~p1_fire;
      p2_col_n  <= P2_EN ? scan(p2_keys, row_sel_n) : 4'hF;
      p2_fire_n <= P2_EN ? ~p2_fire : 1'b1;
    end
  end

endmodule

// File: tb/tb_apf_keypad.sv
// Bench for apf_keypad: directed key/row stimulus queues expected outputs with a
// target cycle; a negedge monitor compares both the P2-enabled and P2-disabled DUTs.
module tb_apf_keypad;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic [10:0] ps2_key;
  logic [3:0]  row_sel_n;
  logic [3:0]  a_p1_col_n, a_p2_col_n, b_p1_col_n, b_p2_col_n;
  logic        a_p1_fire_n, a_p2_fire_n, b_p1_fire_n, b_p2_fire_n;

  always #5 clk_sys = ~clk_sys;

  apf_keypad #(.P2_EN(1'b1)) dut_a (
    .clk_sys(clk_sys), .reset(reset), .ps2_key(ps2_key), .row_sel_n(row_sel_n),
    .p1_col_n(a_p1_col_n), .p2_col_n(a_p2_col_n),
    .p1_fire_n(a_p1_fire_n), .p2_fire_n(a_p2_fire_n)
  );

  apf_keypad #(.P2_EN(1'b0)) dut_b (
    .clk_sys(clk_sys), .reset(reset), .ps2_key(ps2_key), .row_sel_n(row_sel_n),
    .p1_col_n(b_p1_col_n), .p2_col_n(b_p2_col_n),
    .p1_fire_n(b_p1_fire_n), .p2_fire_n(b_p2_fire_n)
  );

  typedef struct {
    int         cyc;
    string      name;
    logic [9:0] exp;   // {p1_col_n, p2_col_n, p1_fire_n, p2_fire_n} for P2_EN=1
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  always @(posedge clk_sys) cyc <= cyc + 1;

  task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s @cyc %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Monitor: compare every expectation that falls due on this cycle.
  always @(negedge clk_sys) begin
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].cyc == cyc) begin
        check({q[i].name, "_p2en"}, {a_p1_col_n, a_p2_col_n, a_p1_fire_n, a_p2_fire_n}, q[i].exp);
        check({q[i].name, "_p2dis"}, {b_p1_col_n, b_p2_col_n, b_p1_fire_n, b_p2_fire_n},
              {q[i].exp[9:6], 4'hF, q[i].exp[1], 1'b1});
        q.delete(i);
      end else if (q[i].cyc < cyc) begin
        check({q[i].name, "_missed"}, 10'h3FF, 10'h000);
        q.delete(i);
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic expect_out(input string name, input int lat, input logic [3:0] c1,
                            input logic [3:0] c2, input logic f1, input logic f2);
    exp_t e;
    e.cyc  = cyc + lat;
    e.name = name;
    e.exp  = {c1, c2, f1, f2};
    q.push_back(e);
  endtask

  task automatic key(input logic press, input logic [8:0] code);
    ps2_key = {~ps2_key[10], press, code};
  endtask

  initial begin
    reset     = 1'b1;
    ps2_key   = 11'h000;
    row_sel_n = 4'hF;
    tick(2);
    // Press of '5' with toggle level 1 arriving during reset must be dropped.
    ps2_key = {1'b1, 1'b1, 9'h02E};
    expect_out("reset_out", 1, 4'hF, 4'hF, 1'b1, 1'b1);
    tick(2);
    reset     = 1'b0;
    row_sel_n = 4'hD;
    expect_out("post_reset", 1, 4'hF, 4'hF, 1'b1, 1'b1);
    expect_out("post_reset_late", 3, 4'hF, 4'hF, 1'b1, 1'b1);
    tick(4);

    // Press '5' (row1 col1): visible two clocks later.
    key(1'b1, 9'h02E);
    expect_out("key5_lat1", 1, 4'hF, 4'hF, 1'b1, 1'b1);
    expect_out("key5_lat2", 2, 4'hD, 4'hF, 1'b1, 1'b1);
    tick(3);
    row_sel_n = 4'hE;
    expect_out("key5_row0", 1, 4'hF, 4'hF, 1'b1, 1'b1);
    tick(2);
    row_sel_n = 4'hC;
    expect_out("key5_rows01", 1, 4'hD, 4'hF, 1'b1, 1'b1);
    tick(2);

    // P1 Up (E0 75) and P2 '8' (075) back to back.
    row_sel_n = 4'hE;
    key(1'b1, 9'h175);
    expect_out("up_lat2", 2, 4'h7, 4'hF, 1'b1, 1'b1);
    tick();
    key(1'b1, 9'h075);
    tick();
    row_sel_n = 4'hB;
    expect_out("p2_8_row2", 1, 4'hF, 4'hD, 1'b1, 1'b1);
    tick(2);
    key(1'b0, 9'h075);
    tick();
    key(1'b0, 9'h175);
    expect_out("p2_8_rel", 1, 4'hF, 4'hF, 1'b1, 1'b1);
    tick(2);
    row_sel_n = 4'hE;
    expect_out("up_rel", 1, 4'hF, 4'hF, 1'b1, 1'b1);
    tick(2);

    // Fire buttons, independent of row scan.
    row_sel_n = 4'hF;
    key(1'b1, 9'h029);
    tick();
    key(1'b1, 9'h014);
    expect_out("fire_p1_only", 1, 4'hF, 4'hF, 1'b0, 1'b1);
    expect_out("fire_both", 2, 4'hF, 4'hF, 1'b0, 1'b0);
    tick(3);
    row_sel_n = 4'h0;
    expect_out("fire_allrows", 1, 4'hD, 4'hF, 1'b0, 1'b0);
    tick(2);
    key(1'b0, 9'h029);
    tick();
    key(1'b0, 9'h014);
    expect_out("fire_rel", 2, 4'hD, 4'hF, 1'b1, 1'b1);
    tick(3);

    // Row change and key event on the same edge: old state, new row first.
    row_sel_n = 4'hD;
    tick(2);
    row_sel_n = 4'hE;
    key(1'b1, 9'h016);
    expect_out("simul_old", 1, 4'hF, 4'hF, 1'b1, 1'b1);
    expect_out("simul_new", 2, 4'hE, 4'hF, 1'b1, 1'b1);
    tick(3);
    key(1'b1, 9'h016);
    expect_out("typematic", 2, 4'hE, 4'hF, 1'b1, 1'b1);
    tick(3);
    key(1'b0, 9'h026);
    expect_out("rel_not_held", 2, 4'hE, 4'hF, 1'b1, 1'b1);
    tick(3);
    key(1'b1, 9'h01A);
    expect_out("unmapped", 2, 4'hE, 4'hF, 1'b1, 1'b1);
    tick(3);
    key(1'b1, 9'h069);
    expect_out("p2_num1", 2, 4'hE, 4'hE, 1'b1, 1'b1);
    tick(3);
    key(1'b1, 9'h15A);
    tick();
    row_sel_n = 4'h7;
    expect_out("p2_enter", 1, 4'hF, 4'hB, 1'b1, 1'b1);
    tick(2);
    key(1'b1, 9'h05A);
    expect_out("p1_enter", 2, 4'hB, 4'hB, 1'b1, 1'b1);
    tick(3);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 20 && q.size() > 0; i++) tick();
    if (q.size() > 0) check("scoreboard_drain", 10'(q.size()), 10'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
